// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush and memory-wait freeze.
// Control outputs are combinational in the same cycle; the memory handshake and perf counters are registered.
module pipeline_stall_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MemValidM,
  input  logic             MemAckM,
  input  logic             CntClr,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushW,
  output logic             MemReqM,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TMO = WW'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t          state;
  logic [WW-1:0]   waitCnt;
  logic            memStall;
  logic            timeoutHit;
  logic            loadUse;
  logic            active;

  always_comb begin
    memStall   = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      S_RUN:  memStall = MemValidM & ~MemAckM;
      S_WAIT: begin
        memStall   = ~MemAckM & (waitCnt < TMO);
        timeoutHit = ~MemAckM & (waitCnt >= TMO);
      end
      default: memStall = 1'b0;
    endcase
  end

  assign loadUse = ResultSrcE0 & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

  // Everything is held low while reset is asserted, even though inputs may be live.
  assign active  = ~rst;
  assign StallF  = active & (memStall | (~PCSrcE & loadUse));
  assign StallD  = StallF;
  assign FlushD  = active & ~memStall & PCSrcE;
  assign FlushE  = active & ~memStall & (PCSrcE | loadUse);
  assign StallE  = active & memStall;
  assign StallM  = active & memStall;
  assign FlushW  = active & memStall;
  assign MemReqM = active & ((state == S_WAIT) | MemValidM);
  assign MemErr  = active & timeoutHit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_RUN;
      waitCnt <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (memStall) begin
            state   <= S_WAIT;
            waitCnt <= WW'(1);
          end
        end
        S_WAIT: begin
          if (MemAckM || timeoutHit) begin
            state   <= S_RUN;
            waitCnt <= '0;
          end else begin
            waitCnt <= waitCnt + WW'(1);
          end
        end
        default: begin
          state   <= S_RUN;
          waitCnt <= '0;
        end
      endcase
    end
  end

  // Clear wins over increment; both counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else if (CntClr) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallF && (StallCount != CNT_MAX)) StallCount <= StallCount + 1'b1;
      if (FlushD && (FlushCount != CNT_MAX)) FlushCount <= FlushCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with TIMEOUT=4 and 4-bit counters.
module tb_pipeline_stall_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, RdE;
  logic       ResultSrcE0, PCSrcE, MemValidM, MemAckM, CntClr;
  logic       StallF, StallD, FlushD, FlushE, StallE, StallM, FlushW, MemReqM, MemErr;
  logic [3:0] StallCount, FlushCount;
  logic [8:0] ctl;

  int checks = 0;
  int errors = 0;

  // ctl = {StallF,StallD,FlushD,FlushE,StallE,StallM,FlushW,MemReqM,MemErr}
  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] LU   = 9'b110100000;
  localparam logic [8:0] BR   = 9'b001100000;
  localparam logic [8:0] MS   = 9'b110011110;
  localparam logic [8:0] MREQ = 9'b000000010;
  localparam logic [8:0] ERR  = 9'b000000011;
  localparam logic [8:0] BRMQ = 9'b001100010;

  pipeline_stall_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .MemValidM(MemValidM), .MemAckM(MemAckM), .CntClr(CntClr),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .StallE(StallE), .StallM(StallM), .FlushW(FlushW),
    .MemReqM(MemReqM), .MemErr(MemErr),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  assign ctl = {StallF, StallD, FlushD, FlushE, StallE, StallM, FlushW, MemReqM, MemErr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; RdE = 0; ResultSrcE0 = 0; PCSrcE = 0;
    MemValidM = 0; MemAckM = 0; CntClr = 0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    MemValidM = 1; PCSrcE = 1; ResultSrcE0 = 1; RdE = 5; Rs1D = 5;
    #2;
    chk("reset_ctl", 32'(ctl), 32'(NONE));
    chk("reset_stallcnt", 32'(StallCount), 0);
    chk("reset_flushcnt", 32'(FlushCount), 0);
    cyc();
    idle();
    rst = 1'b0;
    #1;
    chk("idle_ctl", 32'(ctl), 32'(NONE));
    cyc();

    // Load-use on Rs1 then Rs2, then non-hazard cases
    ResultSrcE0 = 1; RdE = 5; Rs1D = 5; #1;
    chk("loaduse_rs1", 32'(ctl), 32'(LU));
    cyc();
    chk("loaduse_cnt1", 32'(StallCount), 1);
    Rs1D = 0; Rs2D = 5; #1;
    chk("loaduse_rs2", 32'(ctl), 32'(LU));
    cyc();
    RdE = 0; Rs1D = 0; Rs2D = 0; #1;
    chk("loaduse_rd0", 32'(ctl), 32'(NONE));
    cyc();
    ResultSrcE0 = 0; RdE = 7; Rs1D = 7; #1;
    chk("noload_match", 32'(ctl), 32'(NONE));
    cyc();
    chk("stallcnt_2", 32'(StallCount), 2);

    // Branch overriding a load-use
    ResultSrcE0 = 1; RdE = 5; Rs1D = 5; PCSrcE = 1; #1;
    chk("branch_lu", 32'(ctl), 32'(BR));
    cyc();
    idle();
    chk("flushcnt_1", 32'(FlushCount), 1);
    chk("stallcnt_br", 32'(StallCount), 2);

    // Memory wait: ack after three stalled cycles
    MemValidM = 1; #1;
    chk("mw_run", 32'(ctl), 32'(MS));
    cyc(); #1;
    chk("mw_wait1", 32'(ctl), 32'(MS));
    cyc(); #1;
    chk("mw_wait2", 32'(ctl), 32'(MS));
    cyc();
    MemAckM = 1; #1;
    chk("mw_ack", 32'(ctl), 32'(MREQ));
    cyc();
    MemValidM = 0; MemAckM = 0; #1;
    chk("mw_back_run", 32'(ctl), 32'(NONE));
    chk("stallcnt_5", 32'(StallCount), 5);

    // Single-cycle access, then a stray ack in RUN
    MemValidM = 1; MemAckM = 1; #1;
    chk("single_cycle", 32'(ctl), 32'(MREQ));
    cyc();
    MemValidM = 0; #1;
    chk("stray_ack", 32'(ctl), 32'(NONE));
    cyc();
    MemAckM = 0;

    // Timeout: 4 stalled cycles then MemErr with stall released
    MemValidM = 1; #1;
    chk("to_run", 32'(ctl), 32'(MS));
    cyc();
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("to_wait%0d", i), 32'(ctl), 32'(MS));
      cyc();
    end
    chk("to_err", 32'(ctl), 32'(ERR));
    cyc();
    // Fresh handshake immediately after: wait counter must restart
    chk("b2b_run", 32'(ctl), 32'(MS));
    cyc();
    chk("b2b_wait1", 32'(ctl), 32'(MS));
    cyc();
    MemAckM = 1; #1;
    chk("b2b_ack", 32'(ctl), 32'(MREQ));
    cyc();
    idle(); #1;
    chk("stallcnt_11", 32'(StallCount), 11);

    // Branch deferred by a memory wait
    MemValidM = 1; PCSrcE = 1; #1;
    chk("defer_run", 32'(ctl), 32'(MS));
    cyc();
    chk("defer_wait1", 32'(ctl), 32'(MS));
    cyc();
    MemAckM = 1; #1;
    chk("defer_ack", 32'(ctl), 32'(BRMQ));
    cyc();
    idle(); #1;
    chk("flushcnt_2", 32'(FlushCount), 2);
    chk("stallcnt_13", 32'(StallCount), 13);

    // Saturation then clear overriding an active stall
    ResultSrcE0 = 1; RdE = 3; Rs2D = 3;
    for (int i = 0; i < 4; i++) cyc();
    chk("stallcnt_sat", 32'(StallCount), 15);
    CntClr = 1;
    cyc();
    chk("clr_stall", 32'(StallCount), 0);
    chk("clr_flush", 32'(FlushCount), 0);
    idle();

    // Reset asserted mid-WAIT
    MemValidM = 1;
    cyc();
    chk("pre_rst_ctl", 32'(ctl), 32'(MS));
    chk("pre_rst_cnt", 32'(StallCount), 1);
    rst = 1'b1; #1;
    chk("rst_wait_ctl", 32'(ctl), 32'(NONE));
    chk("rst_wait_cnt", 32'(StallCount), 0);
    cyc();
    MemValidM = 0; rst = 1'b0; #1;
    chk("post_rst_run", 32'(ctl), 32'(NONE));
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
